// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// one-hot scheduler states and the pin bundle type.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
  } pin_t;

endpackage

// File: rtl/sdram_cmd_arbiter_if.sv
// Handshake and pin bundle between the command arbiter (master) and the
// sub-controllers / SDRAM pins (slave).
interface sdram_cmd_arbiter_if;
  logic        init_done;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  logic        aref_req;
  logic        aref_en;
  logic        aref_done;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic        wr_req;
  logic        wr_en;
  logic        wr_done;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_ba;
  logic        rd_req;
  logic        rd_en;
  logic        rd_done;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_ba;
  logic        Cs_n;
  logic        Ras_n;
  logic        Cas_n;
  logic        We_n;
  logic [12:0] Addr;
  logic [1:0]  Ba;
  logic        busy;
  logic        err_timeout;

  modport master (
    input  init_done, init_cmd, init_addr,
    input  aref_req, aref_done, aref_cmd, aref_addr,
    input  wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
    input  rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
    output aref_en, wr_en, rd_en,
    output Cs_n, Ras_n, Cas_n, We_n, Addr, Ba, busy, err_timeout
  );

  modport slave (
    output init_done, init_cmd, init_addr,
    output aref_req, aref_done, aref_cmd, aref_addr,
    output wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
    output rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
    input  aref_en, wr_en, rd_en,
    input  Cs_n, Ras_n, Cas_n, We_n, Addr, Ba, busy, err_timeout
  );
endinterface

// File: rtl/sdram_grant_wdog.sv
// Grant watchdog: counts cycles while a grant is open; expire is high in the
// last allowed cycle (count == TIMEOUT-1).
module sdram_grant_wdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic sclk,
  input  logic snrst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge sclk or negedge snrst) begin
    if (!snrst)
      cnt_reg <= '0;
    else if (clr)
      cnt_reg <= '0;
    else if (en)
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign expire = en && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command scheduler: refresh first, write/read round-robin, one grant
// at a time with a watchdog that reclaims a grant whose done never arrives.
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input logic                 sclk,
  input logic                 snrst,
  sdram_cmd_arbiter_if.master bus
);

  state_t state_reg;
  logic   last_wr_reg;
  logic   in_grant;
  logic   grant_done;
  logic   wd_expire;
  pin_t   pin;

  assign in_grant = (state_reg == ST_AREF) || (state_reg == ST_WRITE) ||
                    (state_reg == ST_READ);

  // Counter sits at zero outside a grant, so it starts fresh on every entry.
  sdram_grant_wdog #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wdog (
    .sclk  (sclk),
    .snrst (snrst),
    .clr   (!in_grant),
    .en    (in_grant),
    .expire(wd_expire)
  );

  always_comb begin
    grant_done = 1'b0;
    case (state_reg)
      ST_AREF:  grant_done = bus.aref_done;
      ST_WRITE: grant_done = bus.wr_done;
      ST_READ:  grant_done = bus.rd_done;
      default:  grant_done = 1'b0;
    endcase
  end

  always_ff @(posedge sclk or negedge snrst) begin
    if (!snrst) begin
      state_reg       <= ST_IDLE;
      last_wr_reg     <= 1'b0;
      bus.aref_en     <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.rd_en       <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.aref_en     <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.rd_en       <= 1'b0;
      bus.err_timeout <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.init_done)
            state_reg <= ST_ARBIT;
        end
        ST_ARBIT: begin
          if (bus.aref_req) begin
            state_reg   <= ST_AREF;
            bus.aref_en <= 1'b1;
          end else if (bus.wr_req && (!bus.rd_req || !last_wr_reg)) begin
            state_reg   <= ST_WRITE;
            bus.wr_en   <= 1'b1;
            last_wr_reg <= 1'b1;
          end else if (bus.rd_req) begin
            state_reg   <= ST_READ;
            bus.rd_en   <= 1'b1;
            last_wr_reg <= 1'b0;
          end
        end
        ST_AREF, ST_WRITE, ST_READ: begin
          // done takes precedence over a simultaneous expiry
          if (grant_done) begin
            state_reg <= ST_ARBIT;
          end else if (wd_expire) begin
            state_reg       <= ST_ARBIT;
            bus.err_timeout <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pin = '{cmd: CMD_NOP, addr: 13'd0, ba: 2'b00};
    case (state_reg)
      ST_IDLE:  pin = '{cmd: bus.init_cmd, addr: bus.init_addr, ba: 2'b00};
      ST_AREF:  pin = '{cmd: bus.aref_cmd, addr: bus.aref_addr, ba: 2'b00};
      ST_WRITE: pin = '{cmd: bus.wr_cmd,   addr: bus.wr_addr,   ba: bus.wr_ba};
      ST_READ:  pin = '{cmd: bus.rd_cmd,   addr: bus.rd_addr,   ba: bus.rd_ba};
      default:  pin = '{cmd: CMD_NOP, addr: 13'd0, ba: 2'b00};
    endcase
  end

  assign {bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n} = pin.cmd;
  assign bus.Addr = pin.addr;
  assign bus.Ba   = pin.ba;
  assign bus.busy = in_grant;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Randomized bench for sdram_cmd_arbiter against a cycle-level ownership model
// (who holds the bus, how long, who went last).
module tb_sdram_cmd_arbiter;

  localparam int TO     = 16;
  localparam int NCYC   = 3000;
  localparam int OWN_NONE  = 0;  // before init_done
  localparam int OWN_FREE  = 1;  // arbitrating
  localparam int OWN_AREF  = 2;
  localparam int OWN_WRITE = 3;
  localparam int OWN_READ  = 4;

  logic sclk = 1'b0;
  logic snrst = 1'b0;
  always #5 sclk = ~sclk;

  sdram_cmd_arbiter_if bus ();

  sdram_cmd_arbiter #(
    .TIMEOUT(TO),
    .CNT_W  (5)
  ) dut (
    .sclk (sclk),
    .snrst(snrst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // model state
  int m_owner;
  int m_age;
  bit m_fresh;
  bit m_last_wr;
  bit m_err;
  int n_grants = 0;
  int n_timeouts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = OWN_NONE;
    m_age     = 0;
    m_fresh   = 1'b0;
    m_last_wr = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic check_outputs();
    logic [18:0] exp_pins;
    case (m_owner)
      OWN_NONE:  exp_pins = {bus.init_cmd, bus.init_addr, 2'b00};
      OWN_AREF:  exp_pins = {bus.aref_cmd, bus.aref_addr, 2'b00};
      OWN_WRITE: exp_pins = {bus.wr_cmd, bus.wr_addr, bus.wr_ba};
      OWN_READ:  exp_pins = {bus.rd_cmd, bus.rd_addr, bus.rd_ba};
      default:   exp_pins = {4'b0111, 13'd0, 2'b00};
    endcase
    check("pins", {13'd0, bus.Cs_n, bus.Ras_n, bus.Cas_n, bus.We_n, bus.Addr, bus.Ba}, {13'd0, exp_pins});
    check("aref_en", {31'd0, bus.aref_en}, {31'd0, (m_owner == OWN_AREF) && m_fresh});
    check("wr_en", {31'd0, bus.wr_en}, {31'd0, (m_owner == OWN_WRITE) && m_fresh});
    check("rd_en", {31'd0, bus.rd_en}, {31'd0, (m_owner == OWN_READ) && m_fresh});
    check("busy", {31'd0, bus.busy}, {31'd0, m_owner >= OWN_AREF});
    check("err_timeout", {31'd0, bus.err_timeout}, {31'd0, m_err});
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step(input int cyc);
    bit fresh_n;
    bit err_n;
    bit done;
    int pick;
    fresh_n = 1'b0;
    err_n   = 1'b0;
    if (m_owner == OWN_NONE) begin
      if (bus.init_done) m_owner = OWN_FREE;
    end else if (m_owner == OWN_FREE) begin
      pick = OWN_FREE;
      if (bus.aref_req)                   pick = OWN_AREF;
      else if (bus.wr_req && bus.rd_req)  pick = m_last_wr ? OWN_READ : OWN_WRITE;
      else if (bus.wr_req)                pick = OWN_WRITE;
      else if (bus.rd_req)                pick = OWN_READ;
      if (pick != OWN_FREE) begin
        m_owner = pick;
        m_age   = 0;
        fresh_n = 1'b1;
        if (pick == OWN_WRITE) m_last_wr = 1'b1;
        if (pick == OWN_READ)  m_last_wr = 1'b0;
        n_grants++;
        $display("cycle %0d: grant %s", cyc,
                 pick == OWN_AREF ? "AREF" : (pick == OWN_WRITE ? "WRITE" : "READ"));
      end
    end else begin
      done = (m_owner == OWN_AREF)  ? bus.aref_done :
             (m_owner == OWN_WRITE) ? bus.wr_done : bus.rd_done;
      m_age++;  // grant cycles spent so far, including this one
      if (done) begin
        m_owner = OWN_FREE;
      end else if (m_age >= TO) begin
        m_owner = OWN_FREE;
        err_n   = 1'b1;
        n_timeouts++;
        $display("cycle %0d: watchdog reclaimed grant after %0d cycles", cyc, m_age);
      end
    end
    m_fresh = fresh_n;
    m_err   = err_n;
  endtask

  task automatic drive_random(input int cyc, input int done_pct);
    bus.init_done = (cyc < 50) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.init_cmd  = 4'($urandom);
    bus.init_addr = 13'($urandom);
    bus.aref_req  = ($urandom_range(0, 7) == 0);
    bus.aref_done = ($urandom_range(0, 99) < done_pct);
    bus.aref_cmd  = 4'($urandom);
    bus.aref_addr = 13'($urandom);
    bus.wr_req    = 1'($urandom_range(0, 1));
    bus.wr_done   = ($urandom_range(0, 99) < done_pct);
    bus.wr_cmd    = 4'($urandom);
    bus.wr_addr   = 13'($urandom);
    bus.wr_ba     = 2'($urandom);
    bus.rd_req    = 1'($urandom_range(0, 1));
    bus.rd_done   = ($urandom_range(0, 99) < done_pct);
    bus.rd_cmd    = 4'($urandom);
    bus.rd_addr   = 13'($urandom);
    bus.rd_ba     = 2'($urandom);
  endtask

  initial begin
    int pct_tab[4];
    int done_pct;
    bit do_rst;
    pct_tab  = '{0, 4, 20, 60};
    done_pct = 20;

    drive_random(0, done_pct);
    snrst = 1'b0;
    model_reset();
    @(negedge sclk);
    #1;
    check_outputs();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sclk);
      done_pct = pct_tab[(cyc / 250) % 4];
      drive_random(cyc, done_pct);
      do_rst = (cyc > 60) && ($urandom_range(0, 299) == 0);
      snrst  = !do_rst;
      #1;
      if (do_rst) begin
        model_reset();
        $display("cycle %0d: reset pulse", cyc);
      end
      check_outputs();
      if (!do_rst) model_step(cyc);
    end

    $display("%0d grants, %0d watchdog expiries observed by model", n_grants, n_timeouts);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Central SDRAM command scheduler between the init, auto-refresh, write-burst and read-burst sub-controllers.
- Grants the SDRAM command/address bus to one sub-controller at a time: refresh has highest priority; write and read alternate round-robin.
- Drives the final Cs_n/Ras_n/Cas_n/We_n/Addr/Ba to the SDRAM pins.
- Includes a grant watchdog that recovers from a requester that never signals done.

Parameters:
- TIMEOUT, 1024, maximum cycles a grant may stay open without done; legal range 2..65535.
- CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- sclk  in  1  clock
- snrst  in  1  asynchronous, active-low reset
- init_done  in  1  initialization sequence complete (level)
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init
- init_addr  in  13  address from init
- aref_req  in  1  refresh request (level, held until granted)
- aref_en  out  1  refresh grant pulse
- aref_done  in  1  refresh sequence finished
- aref_cmd  in  4  refresh command
- aref_addr  in  13  refresh address
- wr_req  in  1  write request (level)
- wr_en  out  1  write grant pulse
- wr_done  in  1  write burst finished
- wr_cmd  in  4  write command
- wr_addr  in  13  write address
- wr_ba  in  2  write bank
- rd_req  in  1  read request (level)
- rd_en  out  1  read grant pulse
- rd_done  in  1  read burst finished
- rd_cmd  in  4  read command
- rd_addr  in  13  read address
- rd_ba  in  2  read bank
- Cs_n, Ras_n, Cas_n, We_n  out  1 each  SDRAM command pins
- Addr  out  13  SDRAM address
- Ba  out  2  SDRAM bank
- busy  out  1  high in AREF, WRITE or READ
- err_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Command NOP = 4'b0111.
- FSM states, one-hot: IDLE, ARBIT, AREF, WRITE, READ. Reset state IDLE.
- Reset values: all *_en=0, err_timeout=0, last_wr=0 (so write wins the first tie), watchdog=0.
- IDLE -> ARBIT on the first edge with init_done=1. init_done is ignored once ARBIT has been reached.
- ARBIT decision at each clock edge, checked in this order:
  - aref_req -> AREF.
  - else wr_req && rd_req -> WRITE if last_wr=0, else READ.
  - else wr_req -> WRITE.
  - else rd_req -> READ.
  - else stay in ARBIT.
- last_wr is updated on entry: WRITE sets it to 1, READ clears it to 0; AREF leaves it unchanged.
- Grant pulse: the matching *_en is registered and is high for exactly the first cycle in AREF/WRITE/READ. Latency from req sampled in ARBIT to *_en is 1 cycle.
- AREF/WRITE/READ -> ARBIT on the edge where the matching *_done=1.
  - There is always at least one ARBIT cycle between grants; no back-to-back grant.
  - Done inputs of non-granted requesters are ignored.
- No preemption: aref_req arriving during WRITE/READ waits for that requester's done, then wins in ARBIT.
- Watchdog:
  - Counter clears on entry to any grant state and increments every cycle in it.
  - If it reaches TIMEOUT-1 with no done, the next edge goes to ARBIT and err_timeout pulses for 1 cycle (coincident with the ARBIT cycle).
  - done and expiry in the same cycle: done wins, no error.
- Output mux (combinational from state):
  - IDLE: init_cmd/init_addr, Ba=2'b00.
  - AREF: aref_cmd/aref_addr, Ba=2'b00.
  - WRITE: wr_*.
  - READ: rd_*.
  - ARBIT: NOP, Addr=0, Ba=0.
- busy = state is AREF, WRITE or READ.
- Reset asserted mid-grant: immediate return to IDLE, all outputs to reset values; pins follow init_cmd.

Decomposition:
- Shared package sdram_pkg:
  - CMD_NOP=4'b0111, CMD_PRE, CMD_AREF, CMD_MRS, CMD_ACT, CMD_WR, CMD_RD.
  - State localparams.
- Optional sub-module sdram_grant_wdog: counter with clear, enable, and expiry pulse output, parameterised by TIMEOUT/CNT_W.

Test Plan:
- Reset release with init_done=0 for 50 cycles, then 1 -> pins equal init_cmd during IDLE; ARBIT on the next edge; pins show 0111.
- aref_req=1 in ARBIT -> aref_en high for 1 cycle, 1 cycle later; aref_done after 8 cycles -> back in ARBIT; busy high for 8 cycles.
- wr_req and rd_req both held high for 4 grants, done 5 cycles after each en -> grant order WRITE, READ, WRITE, READ; each separated by one NOP cycle.
- WRITE active, aref_req raised mid-burst -> no aref_en until wr_done; then AREF wins over pending rd_req.
- TIMEOUT=16, wr_done never asserted -> ARBIT after 16 cycles in WRITE, with err_timeout a single pulse; repeat with wr_done at cycle 15 -> no error.
- snrst pulsed low during READ -> state IDLE, rd_en=0, err_timeout=0; pins follow init_cmd.
